// File: rtl/instr_fetch_if.sv
// Fetch <-> decode/execute bundle: hazard/redirect controls in, registered instruction out.
// The master side is the fetch stage; the slave side is decode/execute.
interface instr_fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_pc,
    output instr, opcode, instr_pc, pc_plus4, instr_valid, halted, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc,
    input  instr, opcode, instr_pc, pc_plus4, instr_valid, halted, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC + word ROM, one registered instruction per cycle, 1-edge latency.
// Stall freezes all state; redirect squashes the in-flight word (one bubble); halt opcode parks fetch until reset.
module instr_fetch #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter string       INIT_FILE = "imem.mem",
  parameter logic [5:0]  HALT_OP   = 6'b111111
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.master fif
);

  typedef enum logic {RUN, HALTED} state_t;

  logic [31:0] rom [0:(1 << ADDR_W) - 1];

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic        halt_hit;

  assign halt_hit = instr_valid && (instr[31:26] == HALT_OP) && !fif.stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      pc_plus4    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      // A consumed instruction is one presented while decode is not stalled.
      if (instr_valid && !fif.stall && fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;

      case (state)
        RUN: begin
          if (halt_hit) begin
            // Halt beats a coincident redirect; pc is left where it is.
            state       <= HALTED;
            halted      <= 1'b1;
            instr       <= '0;
            instr_pc    <= '0;
            pc_plus4    <= '0;
            instr_valid <= 1'b0;
          end else if (fif.redirect) begin
            pc          <= fif.redirect_pc & 32'hFFFF_FFFC;
            instr       <= '0;
            instr_pc    <= '0;
            pc_plus4    <= '0;
            instr_valid <= 1'b0;
          end else if (!fif.stall) begin
            instr       <= rom[pc[ADDR_W+1:2]];
            instr_pc    <= pc;
            pc_plus4    <= pc + 32'd4;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
          end
        end
        HALTED: begin
          instr       <= '0;
          instr_pc    <= '0;
          pc_plus4    <= '0;
          instr_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign fif.instr       = instr;
  assign fif.opcode      = instr[31:26];
  assign fif.instr_pc    = instr_pc;
  assign fif.pc_plus4    = pc_plus4;
  assign fif.instr_valid = instr_valid;
  assign fif.halted      = halted;
  assign fif.fetch_count = fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a full-depth instance plus a 4-word instance for address aliasing.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  instr_fetch_if fif ();
  instr_fetch_if fif2 ();

  instr_fetch #(.ADDR_W(8), .RESET_PC(32'h0), .INIT_FILE(""), .HALT_OP(6'b111111)) dut (
    .clk(clk), .reset(reset), .fif(fif.master)
  );

  instr_fetch #(.ADDR_W(2), .RESET_PC(32'h0), .INIT_FILE(""), .HALT_OP(6'b111111)) dut2 (
    .clk(clk), .reset(reset), .fif(fif2.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    fif.stall = 1'b0;
    fif.redirect = 1'b0;
    fif.redirect_pc = 32'h0;
    fif2.stall = 1'b0;
    fif2.redirect = 1'b0;
    fif2.redirect_pc = 32'h0;

    for (int i = 0; i < 256; i++) dut.rom[i] = 32'hA000_0000 + i;
    dut.rom[0] = 32'h1111_1111;
    dut.rom[1] = 32'h2222_2222;
    dut.rom[2] = 32'h3333_3333;
    dut.rom[3] = 32'h4444_4444;
    dut.rom[11] = 32'hBBBB_000B;
    dut.rom[255] = 32'hEEEE_00FF;
    for (int i = 0; i < 4; i++) dut2.rom[i] = 32'hC000_0000 + i;

    step();
    step();
    chk("rst_instr",  fif.instr, 32'h0);
    chk("rst_valid",  {31'b0, fif.instr_valid}, 32'h0);
    chk("rst_ipc",    fif.instr_pc, 32'h0);
    chk("rst_pc4",    fif.pc_plus4, 32'h0);
    chk("rst_count",  fif.fetch_count, 32'h0);
    chk("rst_opcode", {26'b0, fif.opcode}, 32'h0);
    chk("rst_halted", {31'b0, fif.halted}, 32'h0);

    // Sequential fetch
    reset = 1'b0;
    step();
    chk("seq0_instr", fif.instr, 32'h1111_1111);
    chk("seq0_ipc",   fif.instr_pc, 32'h0);
    chk("seq0_pc4",   fif.pc_plus4, 32'h4);
    chk("seq0_valid", {31'b0, fif.instr_valid}, 32'h1);
    chk("seq0_count", fif.fetch_count, 32'h0);
    chk("wrap_a0",    fif2.instr, 32'hC000_0000);
    step();
    chk("seq1_instr", fif.instr, 32'h2222_2222);
    chk("seq1_ipc",   fif.instr_pc, 32'h4);
    chk("seq1_count", fif.fetch_count, 32'h1);
    step();
    chk("seq2_instr", fif.instr, 32'h3333_3333);
    chk("seq2_ipc",   fif.instr_pc, 32'h8);
    chk("seq2_count", fif.fetch_count, 32'h2);

    // Stall for three edges while instr_pc = 8
    fif.stall = 1'b1;
    step();
    chk("stall1_ipc", fif.instr_pc, 32'h8);
    step();
    chk("wrap_ipc",   fif2.instr_pc, 32'h10);
    chk("wrap_instr", fif2.instr, 32'hC000_0000);
    step();
    chk("wrap_ipc2",  fif2.instr_pc, 32'h14);
    chk("wrap_instr2", fif2.instr, 32'hC000_0001);
    chk("stall3_instr", fif.instr, 32'h3333_3333);
    chk("stall3_ipc",   fif.instr_pc, 32'h8);
    chk("stall3_count", fif.fetch_count, 32'h2);
    fif.stall = 1'b0;
    step();
    chk("post_stall_ipc",   fif.instr_pc, 32'hC);
    chk("post_stall_instr", fif.instr, 32'h4444_4444);
    chk("post_stall_count", fif.fetch_count, 32'h3);

    // Redirect to 0x2E while pc = 0x10
    fif.redirect = 1'b1;
    fif.redirect_pc = 32'h0000_002E;
    step();
    chk("redir_bub_valid", {31'b0, fif.instr_valid}, 32'h0);
    chk("redir_bub_instr", fif.instr, 32'h0);
    chk("redir_bub_ipc",   fif.instr_pc, 32'h0);
    chk("redir_bub_count", fif.fetch_count, 32'h4);
    fif.redirect = 1'b0;
    step();
    chk("redir_tgt_ipc",   fif.instr_pc, 32'h2C);
    chk("redir_tgt_instr", fif.instr, 32'hBBBB_000B);
    chk("redir_tgt_pc4",   fif.pc_plus4, 32'h30);
    chk("redir_tgt_valid", {31'b0, fif.instr_valid}, 32'h1);

    // Redirect with simultaneous stall
    fif.redirect = 1'b1;
    fif.stall = 1'b1;
    step();
    chk("rs_bub_valid", {31'b0, fif.instr_valid}, 32'h0);
    chk("rs_bub_instr", fif.instr, 32'h0);
    chk("rs_bub_count", fif.fetch_count, 32'h4);
    fif.redirect = 1'b0;
    fif.stall = 1'b0;
    step();
    chk("rs_tgt_ipc",   fif.instr_pc, 32'h2C);
    chk("rs_tgt_instr", fif.instr, 32'hBBBB_000B);

    // Redirect to the top word; the PC increment wraps to 0
    fif.redirect = 1'b1;
    fif.redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("top_bub_count", fif.fetch_count, 32'h5);
    fif.redirect = 1'b0;
    step();
    chk("top_ipc",   fif.instr_pc, 32'hFFFF_FFFC);
    chk("top_instr", fif.instr, 32'hEEEE_00FF);
    chk("top_pc4",   fif.pc_plus4, 32'h0);
    step();
    chk("pcwrap_ipc",   fif.instr_pc, 32'h0);
    chk("pcwrap_instr", fif.instr, 32'h1111_1111);

    // Reset while stall and redirect are both high
    fif.stall = 1'b1;
    fif.redirect = 1'b1;
    fif.redirect_pc = 32'h0000_0040;
    reset = 1'b1;
    step();
    chk("rsr_instr", fif.instr, 32'h0);
    chk("rsr_ipc",   fif.instr_pc, 32'h0);
    chk("rsr_pc4",   fif.pc_plus4, 32'h0);
    chk("rsr_valid", {31'b0, fif.instr_valid}, 32'h0);
    chk("rsr_count", fif.fetch_count, 32'h0);
    fif.stall = 1'b0;
    fif.redirect = 1'b0;

    // Halt: ROM[2] carries the halt opcode
    dut.rom[2] = 32'hFC00_0000;
    reset = 1'b0;
    step();
    chk("h0_instr", fif.instr, 32'h1111_1111);
    step();
    step();
    chk("h2_opcode", {26'b0, fif.opcode}, 32'h3F);
    chk("h2_ipc",    fif.instr_pc, 32'h8);
    chk("h2_count",  fif.fetch_count, 32'h2);
    chk("h2_halted", {31'b0, fif.halted}, 32'h0);
    step();
    chk("halt_halted", {31'b0, fif.halted}, 32'h1);
    chk("halt_valid",  {31'b0, fif.instr_valid}, 32'h0);
    chk("halt_instr",  fif.instr, 32'h0);
    chk("halt_ipc",    fif.instr_pc, 32'h0);
    chk("halt_count",  fif.fetch_count, 32'h3);
    fif.redirect = 1'b1;
    fif.redirect_pc = 32'h0000_0020;
    step();
    fif.redirect = 1'b0;
    step();
    chk("hredir_halted", {31'b0, fif.halted}, 32'h1);
    chk("hredir_valid",  {31'b0, fif.instr_valid}, 32'h0);
    chk("hredir_ipc",    fif.instr_pc, 32'h0);
    chk("hredir_count",  fif.fetch_count, 32'h3);
    reset = 1'b1;
    step();
    chk("hrst_halted", {31'b0, fif.halted}, 32'h0);
    chk("hrst_count",  fif.fetch_count, 32'h0);
    reset = 1'b0;
    step();
    chk("hrun_instr", fif.instr, 32'h1111_1111);
    chk("hrun_valid", {31'b0, fif.instr_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
